// File: rtl/prng_pkg.sv
// Shared constants, FSM encoding and bit-manipulation helpers for the PRNG
// output-permutation inverse.
package prng_pkg;

   localparam int DATA_W   = 64;
   localparam int XSHIFT   = 6;
   localparam int ROT_BITS = 6;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   // A double-width shift keeps rotl64(v,0) == v without any shift-by-64 term.
   function automatic logic [DATA_W-1:0] rotl64(input logic [DATA_W-1:0] v,
                                               input logic [ROT_BITS-1:0] s);
      logic [2*DATA_W-1:0] d;
      d = {v, v} << s;
      return d[2*DATA_W-1:DATA_W];
   endfunction

   // Undo y = x ^ (x >> XSHIFT) by folding in every shift multiple below DATA_W.
   function automatic logic [DATA_W-1:0] inv_xorshift64(input logic [DATA_W-1:0] y);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k * XSHIFT < DATA_W; k++) begin
         r = r ^ (y >> (k * XSHIFT));
      end
      return r;
   endfunction

endpackage

// File: rtl/perm_inverse_search_check.sv
// Combinational test of one rotation candidate: un-rotate z by c and see whether
// the top ROT_BITS of the result name that same rotation.
module perm_candidate_check
   import prng_pkg::*;
(
   input  logic [DATA_W-1:0]   z,
   input  logic [ROT_BITS-1:0] c,
   output logic [DATA_W-1:0]   y,
   output logic                match
);

   assign y     = rotl64(z, c);
   assign match = (y[DATA_W-1 -: ROT_BITS] == c);

endmodule

// File: rtl/perm_inverse_search.sv
// Recovers the pre-permutation LCG state from a permuted word using a fixed
// 64-cycle rotation search followed by an xorshift inversion.
module perm_inverse_search
   import prng_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   data_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   data_out,
   output logic                found,
   output logic                ambiguous,
   output logic [ROT_BITS-1:0] rot_out
);

   state_t              state_reg;
   logic [DATA_W-1:0]   z_reg;
   logic [DATA_W-1:0]   y_rec_reg;
   logic [ROT_BITS-1:0] cnt_reg;
   logic [ROT_BITS-1:0] c_rec_reg;
   logic                hit_reg;
   logic                multi_reg;
   logic [DATA_W-1:0]   y_cand;
   logic                cand_match;

   perm_candidate_check u_check (
      .z     (z_reg),
      .c     (cnt_reg),
      .y     (y_cand),
      .match (cand_match)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         z_reg     <= '0;
         y_rec_reg <= '0;
         cnt_reg   <= '0;
         c_rec_reg <= '0;
         hit_reg   <= 1'b0;
         multi_reg <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         data_out  <= '0;
         found     <= 1'b0;
         ambiguous <= 1'b0;
         rot_out   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // After a drain, spend one cycle re-opening the input side.
               if (!in_ready) begin
                  in_ready <= 1'b1;
               end else if (in_valid) begin
                  z_reg     <= data_in;
                  cnt_reg   <= '0;
                  hit_reg   <= 1'b0;
                  multi_reg <= 1'b0;
                  in_ready  <= 1'b0;
                  state_reg <= SEARCH;
               end
            end
            SEARCH: begin
               if (cand_match) begin
                  if (!hit_reg) begin
                     hit_reg   <= 1'b1;
                     y_rec_reg <= y_cand;
                     c_rec_reg <= cnt_reg;
                  end else begin
                     multi_reg <= 1'b1;
                  end
               end
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == '1) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; later cycles wait for the sink.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  found     <= hit_reg;
                  ambiguous <= multi_reg;
                  rot_out   <= hit_reg ? c_rec_reg : '0;
                  data_out  <= hit_reg ? inv_xorshift64(y_rec_reg) : '0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perm_inverse_search.sv
// Directed and randomised checks of perm_inverse_search against a forward-permutation model.
module tb_perm_inverse_search;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;
   logic        found;
   logic        ambiguous;
   logic [5:0]  rot_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perm_inverse_search dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .found     (found),
      .ambiguous (ambiguous),
      .rot_out   (rot_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fwd_perm(input logic [63:0] x);
      logic [63:0] y;
      int          r;
      y = x ^ (x >> 6);
      r = int'(x[63:58]);
      return (r == 0) ? y : ((y >> r) | (y << (64 - r)));
   endfunction

   function automatic void model_search(input logic [63:0] z, output int n, output int low);
      logic [63:0] yy;
      n   = 0;
      low = 0;
      for (int c = 0; c < 64; c++) begin
         yy = (c == 0) ? z : ((z << c) | (z >> (64 - c)));
         if (int'(yy[63:58]) == c) begin
            if (n == 0) low = c;
            n++;
         end
      end
   endfunction

   // Called at a negedge; returns just after the accept edge.
   task automatic send(input logic [63:0] z);
      int guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("send_timeout", 64'(guard), 64'd0);
      in_valid = 1'b1;
      data_in  = z;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = ~z;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
      if (!out_valid) check("out_valid_timeout", 64'(lat), 64'd65);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_ready_late"}, 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic run_directed(input string tag, input logic [63:0] z, input logic [63:0] exp_data,
                               input logic exp_found, input logic exp_amb, input logic [5:0] exp_rot);
      int lat;
      send(z);
      wait_out(lat);
      check({tag, "_latency"}, 64'(lat), 64'd65);
      check({tag, "_data"}, data_out, exp_data);
      check({tag, "_found"}, 64'(found), 64'(exp_found));
      check({tag, "_amb"}, 64'(ambiguous), 64'(exp_amb));
      check({tag, "_rot"}, 64'(rot_out), 64'(exp_rot));
      $display("txn %s z=%h data=%h found=%0d amb=%0d rot=%0d lat=%0d",
               tag, z, data_out, found, ambiguous, rot_out, lat);
   endtask

   initial begin
      int          lat;
      int          n;
      int          low;
      logic [63:0] x;
      logic [63:0] z;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data", data_out, 64'd0);
      check("rst_found", 64'(found), 64'd0);
      check("rst_amb", 64'(ambiguous), 64'd0);
      check("rst_rot", 64'(rot_out), 64'd0);

      // z=0: only rotation 0 leaves a top field equal to its own index.
      run_directed("zero", 64'h0, 64'h0, 1'b1, 1'b0, 6'd0);
      drain("zero");

      // Image of x=2^63 (rotation 32); rotation 0 also matches and wins as lowest,
      // giving preimage 2^31, whose own forward image is the same z.
      run_directed("msb_img", 64'h0000_0000_8200_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b1, 6'd0);
      drain("msb_img");

      run_directed("no_pre", 64'h8000_0000_0000_0000, 64'h0, 1'b0, 1'b0, 6'd0);
      drain("no_pre");

      // Back-pressure: results hold, a second request is ignored.
      run_directed("bp", 64'h0000_0000_8200_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b1, 6'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            in_valid = 1'b1;
            data_in  = 64'h8000_0000_0000_0000;
         end
         if (i == 19) in_valid = 1'b0;
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_data", data_out, 64'h0000_0000_8000_0000);
         check("bp_found", 64'(found), 64'd1);
         check("bp_amb", 64'(ambiguous), 64'd1);
      end
      drain("bp");
      repeat (3) @(negedge clk);
      check("bp_no_accept", 64'(in_ready), 64'd1);
      check("bp_no_result", 64'(out_valid), 64'd0);

      // Reset during search discards the pending job and the old outputs.
      send(64'h0123_4567_89ab_cdef);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_data", data_out, 64'd0);
      check("mid_rst_found", 64'(found), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_directed("after_rst", 64'h0, 64'h0, 1'b1, 1'b0, 6'd0);
      drain("after_rst");

      for (int t = 0; t < 1000; t++) begin
         x = {$urandom(), $urandom()};
         z = fwd_perm(x);
         model_search(z, n, low);
         send(z);
         wait_out(lat);
         check("rnd_latency", 64'(lat), 64'd65);
         check("rnd_found", 64'(found), 64'd1);
         check("rnd_amb", 64'(ambiguous), 64'(n >= 2));
         check("rnd_rot", 64'(rot_out), 64'(low));
         check("rnd_preimage", fwd_perm(data_out), z);
         if (n == 1) check("rnd_exact", data_out, x);
         $display("txn rnd%0d x=%h z=%h data=%h matches=%0d rot=%0d", t, x, z, data_out, n, rot_out);
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
